// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// Issue stage in front of an 8-bit ALU slice made of three units:
// adder/subtractor, AND and OR. One packet {op, a, b} is accepted at a time.
// Its operands are registered and exactly one unit enable is pulsed for one
// cycle. The enabled unit's answer is then captured together with its flags,
// and the result is offered downstream until it is taken.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        upstream handshake
//   in_op, in_a, in_b        packet: op 00=ADD 01=SUB 10=AND 11=OR
//   alu_a, alu_b, alu_sub    registered operands / subtract mode to the units
//   add_en, and_en, or_en    one-cycle unit enables (one-hot or all zero)
//   add_result               {carry, sum} from the adder/subtractor
//   and_result, or_result    AND / OR unit answers
//   out_valid/out_ready      downstream handshake
//   out_result, out_carry,
//   out_zero, out_op         registered result, flags and opcode
//   op_count                 completed output transfers (wraps at CNT_W bits)
//   out_overflow             signed overflow flag, only present when the
//                            ALU_ISSUE_OVF_EN macro is defined
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic             alu_sub,
  output logic             add_en,
  output logic             and_en,
  output logic             or_en,
  input  logic [8:0]       add_result,
  input  logic [7:0]       and_result,
  input  logic [7:0]       or_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [1:0]       out_op,
  output logic [CNT_W-1:0] op_count
`ifdef ALU_ISSUE_OVF_EN
  ,
  output logic             out_overflow
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       alu_op_q, alu_op_d;
  logic [7:0]       alu_a_q, alu_a_d;
  logic [7:0]       alu_b_q, alu_b_d;
  logic             alu_sub_q, alu_sub_d;
  logic             add_en_q, add_en_d;
  logic             and_en_q, and_en_d;
  logic             or_en_q, or_en_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_result_q, out_result_d;
  logic             out_carry_q, out_carry_d;
  logic             out_zero_q, out_zero_d;
  logic [1:0]       out_op_q, out_op_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             in_ready_w;
  logic             accept_w;
  logic [7:0]       sel_result_w;
  logic             sel_carry_w;

`ifdef ALU_ISSUE_OVF_EN
  logic             out_overflow_q, out_overflow_d;
  logic             sel_ovf_w;
`endif

  // Accept in IDLE, or in HOLD in the same cycle the current result leaves.
  assign in_ready_w = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
  assign accept_w   = in_valid & in_ready_w;

  // Pick only the unit that was enabled; the others may hold stale data.
  always_comb begin
    sel_result_w = add_result[7:0];
    sel_carry_w  = 1'b0;
    case (alu_op_q)
      OP_ADD, OP_SUB: begin
        sel_result_w = add_result[7:0];
        sel_carry_w  = add_result[8];
      end
      OP_AND:  sel_result_w = and_result;
      OP_OR:   sel_result_w = or_result;
      default: sel_result_w = add_result[7:0];
    endcase
  end

`ifdef ALU_ISSUE_OVF_EN
  // Signed overflow from operand and result sign bits.
  always_comb begin
    sel_ovf_w = 1'b0;
    case (alu_op_q)
      OP_ADD:  sel_ovf_w = (alu_a_q[7] == alu_b_q[7]) & (add_result[7] != alu_a_q[7]);
      OP_SUB:  sel_ovf_w = (alu_a_q[7] != alu_b_q[7]) & (add_result[7] != alu_a_q[7]);
      default: sel_ovf_w = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d      = state_q;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    // Enables and subtract mode are pulses: high only in the cycle after accept.
    alu_sub_d    = 1'b0;
    add_en_d     = 1'b0;
    and_en_d     = 1'b0;
    or_en_d      = 1'b0;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_zero_d   = out_zero_q;
    out_op_d     = out_op_q;
    op_count_d   = op_count_q;
`ifdef ALU_ISSUE_OVF_EN
    out_overflow_d = out_overflow_q;
`endif

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_DRIVE: begin
        out_result_d = sel_result_w;
        out_carry_d  = sel_carry_w;
        out_zero_d   = (sel_result_w == 8'h00);
        out_op_d     = alu_op_q;
        out_valid_d  = 1'b1;
`ifdef ALU_ISSUE_OVF_EN
        out_overflow_d = sel_ovf_w;
`endif
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          op_count_d  = op_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A new packet overrides the IDLE return when it arrives during HOLD.
    if (accept_w) begin
      alu_op_d  = in_op;
      alu_a_d   = in_a;
      alu_b_d   = in_b;
      add_en_d  = (in_op == OP_ADD) | (in_op == OP_SUB);
      alu_sub_d = (in_op == OP_SUB);
      and_en_d  = (in_op == OP_AND);
      or_en_d   = (in_op == OP_OR);
      state_d   = ST_DRIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      alu_op_q     <= 2'b00;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_sub_q    <= 1'b0;
      add_en_q     <= 1'b0;
      and_en_q     <= 1'b0;
      or_en_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= 8'h00;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_op_q     <= 2'b00;
      op_count_q   <= '0;
`ifdef ALU_ISSUE_OVF_EN
      out_overflow_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sub_q    <= alu_sub_d;
      add_en_q     <= add_en_d;
      and_en_q     <= and_en_d;
      or_en_q      <= or_en_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
      out_op_q     <= out_op_d;
      op_count_q   <= op_count_d;
`ifdef ALU_ISSUE_OVF_EN
      out_overflow_q <= out_overflow_d;
`endif
    end
  end

  assign in_ready   = in_ready_w;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sub    = alu_sub_q;
  assign add_en     = add_en_q;
  assign and_en     = and_en_q;
  assign or_en      = or_en_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_carry  = out_carry_q;
  assign out_zero   = out_zero_q;
  assign out_op     = out_op_q;
  assign op_count   = op_count_q;
`ifdef ALU_ISSUE_OVF_EN
  assign out_overflow = out_overflow_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Bench for alu_issue_ctrl. Behavioural ALU units answer only when enabled and
// return random junk otherwise. A transaction-level model (one packet in
// flight, its age in cycles, a transfer counter) predicts handshakes, enables
// and results each cycle. Directed steps cover the listed corner cases, then
// a randomized phase runs with random valid/ready patterns.
// -----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [7:0]       in_a;
  logic [7:0]       in_b;
  logic [7:0]       alu_a;
  logic [7:0]       alu_b;
  logic             alu_sub;
  logic             add_en;
  logic             and_en;
  logic             or_en;
  logic [8:0]       add_result;
  logic [7:0]       and_result;
  logic [7:0]       or_result;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_result;
  logic             out_carry;
  logic             out_zero;
  logic [1:0]       out_op;
  logic [CNT_W-1:0] op_count;
`ifdef ALU_ISSUE_OVF_EN
  logic             out_overflow;
`endif

  alu_issue_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sub    (alu_sub),
    .add_en     (add_en),
    .and_en     (and_en),
    .or_en      (or_en),
    .add_result (add_result),
    .and_result (and_result),
    .or_result  (or_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_op     (out_op),
    .op_count   (op_count)
`ifdef ALU_ISSUE_OVF_EN
    ,
    .out_overflow (out_overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU units: correct answer when enabled, junk otherwise.
  logic [31:0] junk;
  always @(posedge clk) junk <= $urandom;

  assign add_result = add_en ? (alu_sub ? ({1'b0, alu_a} + {1'b0, ~alu_b} + 9'd1)
                                        : ({1'b0, alu_a} + {1'b0, alu_b}))
                             : junk[8:0];
  assign and_result = and_en ? (alu_a & alu_b) : junk[16:9];
  assign or_result  = or_en  ? (alu_a | alu_b) : junk[24:17];

  int unsigned vectors;
  int unsigned miscompares;

  // Transaction-level model state.
  bit          model_on;
  bit          m_busy;
  int          m_age;
  logic [1:0]  m_op;
  logic [7:0]  m_a;
  logic [7:0]  m_b;
  logic [15:0] m_count;
  bit          in_fire;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU from plain integer arithmetic.
  function automatic void ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output logic v);
    int ua, ub, sa, sb, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    r = 8'h00; c = 1'b0; v = 1'b0;
    case (op)
      2'd0: begin
        s = ua + ub; r = 8'(s); c = (s > 255);
        s = sa + sb; v = (s > 127) || (s < -128);
      end
      2'd1: begin
        s = ua - ub; r = 8'(s); c = (ua >= ub);
        s = sa - sb; v = (s > 127) || (s < -128);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
  endfunction

  // One clock cycle: settle inputs, check against the model, update the
  // model with the handshakes of the coming edge, then advance.
  task automatic cycle();
    logic       exp_valid, exp_ready;
    logic [7:0] r;
    logic       c, v;
    #1;
    in_fire = 1'b0;
    if (model_on) begin
      exp_valid = m_busy && (m_age >= 2);
      exp_ready = !m_busy || ((m_age >= 2) && out_ready);
      chk("in_ready", in_ready, exp_ready);
      chk("out_valid", out_valid, exp_valid);
      chk("op_count", op_count, m_count);
      chk("add_en", add_en, m_busy && m_age == 1 && m_op[1] == 1'b0);
      chk("alu_sub", alu_sub, m_busy && m_age == 1 && m_op == 2'd1);
      chk("and_en", and_en, m_busy && m_age == 1 && m_op == 2'd2);
      chk("or_en", or_en, m_busy && m_age == 1 && m_op == 2'd3);
      if (m_busy && m_age >= 1) begin
        chk("alu_a", alu_a, m_a);
        chk("alu_b", alu_b, m_b);
      end
      if (exp_valid) begin
        ref_alu(m_op, m_a, m_b, r, c, v);
        chk("out_result", out_result, r);
        chk("out_carry", out_carry, c);
        chk("out_zero", out_zero, r == 8'h00);
        chk("out_op", out_op, m_op);
`ifdef ALU_ISSUE_OVF_EN
        chk("out_overflow", out_overflow, v);
`endif
      end
      if (exp_valid && out_ready) begin
        m_busy = 1'b0;
        m_count++;
      end
      if (in_valid && exp_ready) begin
        in_fire = 1'b1;
        m_busy  = 1'b1;
        m_age   = 0;
        m_op    = in_op;
        m_a     = in_a;
        m_b     = in_b;
      end
      if (rst) begin
        m_busy  = 1'b0;
        m_count = '0;
        in_fire = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    if (m_busy) m_age++;
  endtask

  // Single packet with out_ready held high and constant expected values.
  task automatic directed(input string tag, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] er, input logic ec,
                          input logic ez, input logic ev);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk({tag, "_add_en"}, add_en, (op == 2'd0) || (op == 2'd1));
    chk({tag, "_alu_sub"}, alu_sub, op == 2'd1);
    chk({tag, "_and_en"}, and_en, op == 2'd2);
    chk({tag, "_or_en"}, or_en, op == 2'd3);
    cycle();
    chk({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_result"}, out_result, er);
    chk({tag, "_carry"}, out_carry, ec);
    chk({tag, "_zero"}, out_zero, ez);
    chk({tag, "_op"}, out_op, op);
`ifdef ALU_ISSUE_OVF_EN
    chk({tag, "_ovf"}, out_overflow, ev);
`else
    if (ev === 1'bx) chk({tag, "_ovf_arg"}, 32'd0, 32'd1);
`endif
    cycle();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    model_on = 1'b0; m_busy = 1'b0; m_age = 0; m_count = '0;
    m_op = 2'd0; m_a = 8'h00; m_b = 8'h00; in_fire = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_op = 2'd0; in_a = 8'h00; in_b = 8'h00; out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_op_count", op_count, 16'd0);
    chk("rst_enables", {add_en, and_en, or_en, alu_sub}, 4'b0000);
    chk("rst_operands", {alu_a, alu_b}, 16'h0000);
    chk("rst_outputs", {out_result, out_carry, out_zero, out_op}, 12'h000);
    model_on = 1'b1;

    // Directed arithmetic and logic cases.
    directed("add_7f_01", 2'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    chk("add_7f_01_count", op_count, 16'd1);
    directed("add_ff_01", 2'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    directed("sub_05_05", 2'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
    directed("sub_03_05", 2'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0, 1'b0);
    directed("and_f0_3c", 2'd2, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    directed("or_f0_3c",  2'd3, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
    chk("count_after_directed", op_count, 16'd6);

    // Backpressure with a second packet waiting.
    in_valid = 1'b1; in_op = 2'd2; in_a = 8'hF0; in_b = 8'h3C; out_ready = 1'b0;
    cycle();
    in_op = 2'd3; in_a = 8'h0F; in_b = 8'h30;
    cycle();
    for (int i = 0; i < 5; i++) begin
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_result", out_result, 8'h30);
      chk("bp_op", out_op, 2'd2);
      cycle();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    cycle();
    chk("bp_second_or_en", {add_en, and_en, or_en}, 3'b001);
    chk("bp_second_not_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    cycle();
    chk("bp_second_result", out_result, 8'h3F);
    chk("bp_second_op", out_op, 2'd3);
    cycle();

    // Reset while the packet is in DRIVE.
    in_valid = 1'b1; in_op = 2'd0; in_a = 8'h11; in_b = 8'h22; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("mid_rst_drive", add_en, 1'b1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_ready", in_ready, 1'b1);
    chk("mid_rst_enables", {add_en, and_en, or_en, alu_sub}, 4'b0000);
    chk("mid_rst_count", op_count, 16'd0);
    repeat (4) cycle();

    // Randomized traffic.
    in_valid = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || in_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 2'($urandom_range(0, 3));
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Drain.
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("final_idle_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
